program_loader: RTL and testbench

//   Byte-stream writer for the CPU instruction memory. Receives a framed program image over a

---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/program_loader_adder.sv | 13 +
 rtl/program_loader.sv | 135 +++++++++++++
 tb/tb_program_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package program_loader_pkg;

   // Loader FSM states; receive states are LenHi through Chk.
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLenHi  = 3'd1,
      StLenLo  = 3'd2,
      StDataHi = 3'd3,
      StDataLo = 3'd4,
      StChk    = 3'd5,
      StDone   = 3'd6,
      StError  = 3'd7
   } loaderState_t;

   // True in every state that is waiting for a stream byte.
   function automatic logic isReceiving(input loaderState_t s);
      return (s == StLenHi) || (s == StLenLo) || (s == StDataHi) ||
             (s == StDataLo) || (s == StChk);
   endfunction

   // True in the resting states, where a new load may be started.
   function automatic logic canStart(input loaderState_t s);
      return (s == StIdle) || (s == StDone) || (s == StError);
   endfunction

endpackage

// File: rtl/program_loader_adder.sv
// Word-wide adder shared with the PC logic; used here as the write-address incrementer.
module FullAdder #(
   parameter int l = 16
) (
   input  logic [l-1:0] A,
   input  logic [l-1:0] B,
   input  logic         Cin,
   output logic [l-1:0] Sum
);

   assign Sum = A + B + l'(Cin);

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream, writes 16-bit words into
// instruction memory from address 0 and holds the CPU while loading.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int l         = 16,
   parameter int DepthLog2 = 8
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         Start,
   input  logic         InValid,
   input  logic [7:0]   InByte,
   output logic         InReady,
   output logic         WrEn,
   output logic [l-1:0] WrAddr,
   output logic [l-1:0] WrData,
   output logic         CpuHold,
   output logic         Done,
   output logic         Error
);

   // Largest image that fits; one bit wider than a word so 1<<16 is representable.
   localparam logic [l:0] MaxWords = (l+1)'(64'd1 << DepthLog2);

   loaderState_t state;
   loaderState_t nextState;
   logic [7:0]   hiByte;
   logic [7:0]   checksum;
   logic [l-1:0] wordsLeft;
   logic [l-1:0] addrCnt;
   logic [l-1:0] addrNext;
   logic [l-1:0] lenWord;
   logic         xfer;
   logic         startOk;
   logic         lenOverflow;
   logic         lastWord;

   assign InReady     = isReceiving(state);
   assign xfer        = InValid & InReady;
   assign startOk     = Start & canStart(state);
   assign lenWord     = l'({hiByte, InByte});
   assign lenOverflow = {1'b0, lenWord} > MaxWords;
   assign lastWord    = (wordsLeft == l'(1));

   FullAdder #(.l(l)) addrInc (
      .A   (addrCnt),
      .B   ('0),
      .Cin (1'b1),
      .Sum (addrNext)
   );

   // State register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= StIdle;
      else        state <= nextState;
   end

   // Next-state logic: receive states only advance on an accepted byte.
   always_comb begin
      nextState = state;
      case (state)
         StIdle, StDone, StError: if (Start) nextState = StLenHi;
         StLenHi:  if (xfer) nextState = StLenLo;
         StLenLo: begin
            if (xfer) begin
               if (lenOverflow)          nextState = StError;
               else if (lenWord == '0)   nextState = StChk;
               else                      nextState = StDataHi;
            end
         end
         StDataHi: if (xfer) nextState = StDataLo;
         StDataLo: if (xfer) nextState = lastWord ? StChk : StDataHi;
         StChk:    if (xfer) nextState = (InByte == checksum) ? StDone : StError;
         default:  nextState = StIdle;
      endcase
   end

   // Datapath: byte latch, checksum, word counter, write port and status flags.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         hiByte    <= '0;
         checksum  <= '0;
         wordsLeft <= '0;
         addrCnt   <= '0;
         WrEn      <= 1'b0;
         WrAddr    <= '0;
         WrData    <= '0;
         CpuHold   <= 1'b0;
         Done      <= 1'b0;
         Error     <= 1'b0;
      end else begin
         WrEn <= 1'b0;
         if (startOk) begin
            Done     <= 1'b0;
            Error    <= 1'b0;
            checksum <= '0;
            addrCnt  <= '0;
            WrAddr   <= '0;
            CpuHold  <= 1'b1;
         end
         if (xfer) begin
            case (state)
               StLenHi, StDataHi: begin
                  hiByte   <= InByte;
                  checksum <= checksum ^ InByte;
               end
               StLenLo: begin
                  checksum  <= checksum ^ InByte;
                  wordsLeft <= lenWord;
                  if (lenOverflow) begin
                     Error   <= 1'b1;
                     CpuHold <= 1'b0;
                  end
               end
               StDataLo: begin
                  checksum  <= checksum ^ InByte;
                  WrEn      <= 1'b1;
                  WrAddr    <= addrCnt;
                  WrData    <= l'({hiByte, InByte});
                  addrCnt   <= addrNext;
                  wordsLeft <= wordsLeft - l'(1);
               end
               StChk: begin
                  CpuHold <= 1'b0;
                  if (InByte == checksum) Done  <= 1'b1;
                  else                    Error <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed frames plus random frames checked
// against a frame-level reference model.
module tb_program_loader;

   typedef logic [7:0] byteQ_t[$];

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Start = 1'b0;
   logic        InValid = 1'b0;
   logic [7:0]  InByte = 8'h00;
   logic        InReady, WrEn, CpuHold, Done, Error;
   logic [15:0] WrAddr, WrData;

   int errors = 0;
   int checks = 0;

   logic [31:0] obsQ[$];
   logic [31:0] expQ[$];
   bit          expDone, expError;
   int          consumed;
   int          backToBack = 0;
   int          bothHigh = 0;
   logic        prevWrEn = 1'b0;
   byteQ_t      frame;

   program_loader #(.l(16), .DepthLog2(8)) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Start   (Start),
      .InValid (InValid),
      .InByte  (InByte),
      .InReady (InReady),
      .WrEn    (WrEn),
      .WrAddr  (WrAddr),
      .WrData  (WrData),
      .CpuHold (CpuHold),
      .Done    (Done),
      .Error   (Error)
   );

   // Free-running clock.
   always #5 Clk = ~Clk;

   // Records every memory write and watches invariants, sampled on the falling edge.
   always @(negedge Clk) begin
      if (WrEn) obsQ.push_back({WrAddr, WrData});
      if (WrEn && prevWrEn) backToBack++;
      if (Done && Error) bothHigh++;
      prevWrEn = WrEn;
   end

   // Global time limit so the run can never hang.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference model: expected writes and final status from the frame rules.
   function automatic void modelFrame(input byteQ_t f);
      int n;
      logic [7:0] x;
      expQ.delete();
      n = int'({f[0], f[1]});
      if (n > 256) begin
         expDone  = 1'b0;
         expError = 1'b1;
         consumed = 2;
         return;
      end
      x = f[0] ^ f[1];
      for (int i = 0; i < n; i++) begin
         x ^= f[2+2*i] ^ f[3+2*i];
         expQ.push_back({16'(i), f[2+2*i], f[3+2*i]});
      end
      expDone  = (f[2+2*n] == x);
      expError = !expDone;
      consumed = 2 * n + 3;
   endfunction

   // Builds a random frame of n words, optionally with a corrupted check byte.
   function automatic void makeFrame(input int n, input bit corrupt);
      logic [7:0] x;
      logic [7:0] b;
      frame.delete();
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      x = frame[0] ^ frame[1];
      if (n > 256) begin
         for (int i = 0; i < 4; i++) frame.push_back(8'($urandom));
         return;
      end
      for (int i = 0; i < 2 * n; i++) begin
         b = 8'($urandom);
         x ^= b;
         frame.push_back(b);
      end
      frame.push_back(corrupt ? (x ^ 8'($urandom_range(255, 1))) : x);
   endfunction

   // Offers one byte (after optional idle cycles) until the loader takes it.
   task automatic sendByte(input logic [7:0] b, input int gapPct);
      int budget;
      if (gapPct < 0) begin
         InValid = 1'b0;
         @(posedge Clk); #1;
      end else begin
         while ($urandom_range(99) < gapPct) begin
            InValid = 1'b0;
            @(posedge Clk); #1;
         end
      end
      InValid = 1'b1;
      InByte  = b;
      budget  = 40;
      forever begin
         @(negedge Clk);
         if (InReady) break;
         budget--;
         if (budget == 0) begin
            checkOutput("byteTimeout", {31'd0, InReady}, 32'd1);
            InValid = 1'b0;
            return;
         end
      end
      @(posedge Clk); #1;
      InValid = 1'b0;
   endtask

   // Runs the frame held in 'frame' from Start to completion and checks the outcome.
   task automatic applyStimulus(input string tag, input int gapPct, input bit startWithByte, input bit midStart);
      modelFrame(frame);
      obsQ.delete();
      Start = 1'b1;
      if (startWithByte) begin
         InValid = 1'b1;
         InByte  = 8'hFF;
      end
      @(posedge Clk); #1;
      Start   = 1'b0;
      InValid = 1'b0;
      @(negedge Clk);
      checkOutput({tag, " holdAfterStart"}, {31'd0, CpuHold}, 32'd1);
      checkOutput({tag, " readyAfterStart"}, {31'd0, InReady}, 32'd1);
      checkOutput({tag, " doneCleared"}, {31'd0, Done}, 32'd0);
      checkOutput({tag, " errorCleared"}, {31'd0, Error}, 32'd0);
      @(posedge Clk); #1;
      for (int i = 0; i < consumed; i++) begin
         if (midStart && i == 2) begin
            Start = 1'b1;
            @(posedge Clk); #1;
            Start = 1'b0;
         end
         sendByte(frame[i], gapPct);
      end
      repeat (2) @(negedge Clk);
      checkOutput({tag, " writeCount"}, obsQ.size(), expQ.size());
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++)
         checkOutput({tag, " write"}, obsQ[i], expQ[i]);
      checkOutput({tag, " done"}, {31'd0, Done}, {31'd0, expDone});
      checkOutput({tag, " error"}, {31'd0, Error}, {31'd0, expError});
      checkOutput({tag, " holdReleased"}, {31'd0, CpuHold}, 32'd0);
      checkOutput({tag, " readyLow"}, {31'd0, InReady}, 32'd0);
   endtask

   // Directed sequence followed by random frames.
   initial begin
      int n;
      Rst_n = 1'b0;
      repeat (2) @(negedge Clk);
      checkOutput("reset InReady", {31'd0, InReady}, 32'd0);
      checkOutput("reset WrEn", {31'd0, WrEn}, 32'd0);
      checkOutput("reset CpuHold", {31'd0, CpuHold}, 32'd0);
      checkOutput("reset Done", {31'd0, Done}, 32'd0);
      checkOutput("reset Error", {31'd0, Error}, 32'd0);
      checkOutput("reset WrAddr", {16'd0, WrAddr}, 32'd0);
      checkOutput("reset WrData", {16'd0, WrData}, 32'd0);
      @(posedge Clk); #1;
      Rst_n = 1'b1;

      // Two-word frame with a wrong check byte; its true checksum is 9C.
      frame = {8'h00, 8'h02, 8'hA0, 8'h01, 8'h40, 8'h7F, 8'h1F};
      applyStimulus("badChk", 0, 1'b0, 1'b0);
      checkOutput("badChk ErrorSet", {31'd0, Error}, 32'd1);
      if (obsQ.size() >= 2) begin
         checkOutput("badChk word0", obsQ[0], 32'h0000_A001);
         checkOutput("badChk word1", obsQ[1], 32'h0001_407F);
      end

      frame = {8'h00, 8'h02, 8'hA0, 8'h01, 8'h40, 8'h7F, 8'h1C};
      applyStimulus("chk1C", 0, 1'b0, 1'b0);

      frame = {8'h00, 8'h02, 8'hA0, 8'h01, 8'h40, 8'h7F, 8'h9C};
      applyStimulus("goodChk", 0, 1'b0, 1'b0);
      checkOutput("goodChk DoneSet", {31'd0, Done}, 32'd1);

      frame = {8'h00, 8'h00, 8'h00};
      applyStimulus("empty", 0, 1'b0, 1'b0);
      checkOutput("empty noWrites", obsQ.size(), 32'd0);

      frame = {8'h01, 8'h01, 8'h12, 8'h34};
      applyStimulus("overflow", 0, 1'b0, 1'b0);
      checkOutput("overflow ErrorSet", {31'd0, Error}, 32'd1);

      makeFrame(256, 1'b0);
      applyStimulus("fullMem", 0, 1'b0, 1'b0);
      if (obsQ.size() == 256)
         checkOutput("fullMem lastAddr", {16'd0, obsQ[255][31:16]}, 32'd255);

      frame = {8'h00, 8'h02, 8'hA0, 8'h01, 8'h40, 8'h7F, 8'h9C};
      applyStimulus("toggleValid", -1, 1'b0, 1'b0);

      makeFrame(3, 1'b0);
      applyStimulus("startInDataHi", 0, 1'b0, 1'b1);

      makeFrame(2, 1'b0);
      applyStimulus("startWithByte", 0, 1'b1, 1'b0);

      // Reset after three data bytes of a two-word frame.
      frame = {8'h00, 8'h02, 8'hA0, 8'h01, 8'h40, 8'h7F, 8'h9C};
      obsQ.delete();
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int i = 0; i < 5; i++) sendByte(frame[i], 0);
      checkOutput("midReset firstWrite", obsQ.size(), 32'd1);
      #2 Rst_n = 1'b0;
      @(negedge Clk);
      checkOutput("midReset InReady", {31'd0, InReady}, 32'd0);
      checkOutput("midReset WrEn", {31'd0, WrEn}, 32'd0);
      checkOutput("midReset CpuHold", {31'd0, CpuHold}, 32'd0);
      checkOutput("midReset Done", {31'd0, Done}, 32'd0);
      checkOutput("midReset Error", {31'd0, Error}, 32'd0);
      checkOutput("midReset WrAddr", {16'd0, WrAddr}, 32'd0);
      checkOutput("midReset WrData", {16'd0, WrData}, 32'd0);
      @(posedge Clk); #1;
      Rst_n   = 1'b1;
      InValid = 1'b1;
      InByte  = 8'h7F;
      repeat (4) @(negedge Clk);
      checkOutput("midReset noMoreWrites", obsQ.size(), 32'd1);
      checkOutput("midReset idleReady", {31'd0, InReady}, 32'd0);
      @(posedge Clk); #1;
      InValid = 1'b0;

      // Random frames: mostly short images, some empty, some oversized.
      for (int k = 0; k < 24; k++) begin
         case ($urandom_range(9))
            0:       n = 0;
            1:       n = int'($urandom_range(65535, 257));
            default: n = int'($urandom_range(8, 1));
         endcase
         makeFrame(n, ($urandom_range(9) < 3));
         applyStimulus("random", ($urandom_range(1) == 1) ? 40 : 0, 1'b0, 1'b0);
      end

      checkOutput("neverBackToBackWrEn", backToBack, 32'd0);
      checkOutput("neverDoneAndError", bothHigh, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
